// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 sync/coordinate generator advanced by rising edges of the half-rate pixel clock.
// Define VGA_TEST_PATTERN_EN to drive an 8-bar colour test pattern on rgb; otherwise rgb is constant zero.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        half_in,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic [11:0] rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic        half_q, tick, h_wrap, v_wrap, vis_nxt;
    logic [9:0]  x_nxt, y_nxt;
    logic [11:0] rgb_nxt;

    assign tick    = half_in & ~half_q;
    assign h_wrap  = x == H_LAST;
    assign v_wrap  = y == V_LAST;
    assign x_nxt   = h_wrap ? '0 : x + 10'd1;
    assign y_nxt   = h_wrap ? (v_wrap ? '0 : y + 10'd1) : y;
    assign vis_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};
    logic [2:0] bar;
    // Out-of-range bar indices only occur outside the active area, where rgb is blanked.
    assign bar     = 3'(x_nxt / BAR_W);
    assign rgb_nxt = vis_nxt ? BARS[bar] : 12'h000;
`else
    assign rgb_nxt = 12'h000;
`endif

    // Sync/blank/colour are loaded from the next position so they stay aligned with x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else begin
            half_q      <= half_in;
            frame_start <= tick & h_wrap & v_wrap;
            if (tick) begin
                x        <= x_nxt;
                y        <= y_nxt;
                hsync    <= (x_nxt >= H_SS && x_nxt < H_SE) ? SYNC_POL : ~SYNC_POL;
                vsync    <= (y_nxt >= V_SS && y_nxt < V_SE) ? SYNC_POL : ~SYNC_POL;
                video_on <= vis_nxt;
                rgb      <= rgb_nxt;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen on a scaled-down timing (48x13 total) so full frames fit in a short run.
module tb_vga_sync_gen;
    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int ND = 18;

    logic        clk = 1'b0, rst_n = 1'b1, half_in = 1'b0;
    logic        hsync, vsync, video_on, frame_start;
    logic [9:0]  x, y;
    logic [11:0] rgb;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .half_in(half_in), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .x(x), .y(y), .frame_start(frame_start), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x, y;
        logic        hs, vs, vo, fs;
        logic [11:0] rgb;
    } exp_t;
    exp_t q[$];

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Hand-computed points for the scaled timing: {x, y, hsync, vsync, video_on, bar colour}
    int dtab [ND][6] = '{
        '{1, 0, 1, 1, 1, 'hFFF}, '{4, 1, 1, 1, 1, 'hFF0}, '{8, 4, 1, 1, 1, 'h0FF},
        '{12, 1, 1, 1, 1, 'h0F0}, '{16, 2, 1, 1, 1, 'hF0F}, '{20, 2, 1, 1, 1, 'hF00},
        '{24, 3, 1, 1, 1, 'h00F}, '{28, 2, 1, 1, 1, 'h000}, '{31, 5, 1, 1, 1, 'h000},
        '{32, 0, 1, 1, 0, 'h000}, '{36, 0, 0, 1, 0, 'h000}, '{41, 3, 0, 1, 0, 'h000},
        '{42, 3, 1, 1, 0, 'h000}, '{0, 6, 1, 1, 0, 'h000}, '{10, 8, 1, 0, 0, 'h000},
        '{40, 9, 0, 0, 0, 'h000}, '{5, 10, 1, 1, 0, 'h000}, '{47, 12, 1, 1, 0, 'h000}
    };
    bit dhit [ND];

    logic        mhq, mhs, mvs, mvo, mfs;
    logic [9:0]  mx, my;
    logic [11:0] mrgb;
    int          mpulses;

    function automatic logic [11:0] pat(input int px, input int py);
`ifdef VGA_TEST_PATTERN_EN
        logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return (px < HA && py < VA) ? bars[px / (HA / 8)] : 12'h000;
`else
        return 12'h000;
`endif
    endfunction

    task automatic model_reset();
        mhq = 0; mx = 0; my = 0; mhs = 1; mvs = 1; mvo = 0; mfs = 0; mrgb = 0; mpulses = 0;
    endtask

    task automatic model_step();
        logic t;
        if (!rst_n) begin
            model_reset();
        end else begin
            t   = half_in & ~mhq;
            mhq = half_in;
            mfs = t && mx == 10'(HT - 1) && my == 10'(VT - 1);
            if (mfs) mpulses++;
            if (t) begin
                if (mx == 10'(HT - 1)) begin
                    mx = 0;
                    my = (my == 10'(VT - 1)) ? 10'd0 : my + 10'd1;
                end else begin
                    mx = mx + 10'd1;
                end
                mhs  = !(mx >= HA + HF && mx < HA + HF + HS);
                mvs  = !(my >= VA + VF && my < VA + VF + VS);
                mvo  = mx < HA && my < VA;
                mrgb = pat(int'(mx), int'(my));
            end
        end
    endtask

    task automatic cyc(input logic h);
        exp_t e;
        half_in = h;
        @(posedge clk);
        model_step();
        #1;
        e = '{x: mx, y: my, hs: mhs, vs: mvs, vo: mvo, fs: mfs, rgb: mrgb};
        q.push_back(e);
    endtask

    task automatic reset_checks();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video_on", video_on, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_rgb", rgb, 0);
    endtask

    // Monitor: pops one expected state per cycle and measures frame_start spacing.
    int clk_n = 0, last_fs = 0, fs_cnt = 0, intervals = 0;
    always @(negedge clk) begin
        exp_t e;
        clk_n++;
        if (!rst_n) fs_cnt = 0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("x", x, e.x);
            chk("y", y, e.y);
            chk("hsync", hsync, e.hs);
            chk("vsync", vsync, e.vs);
            chk("video_on", video_on, e.vo);
            chk("frame_start", frame_start, e.fs);
            chk("rgb", rgb, e.rgb);
            for (int k = 0; k < ND; k++)
                if (!dhit[k] && rst_n && int'(e.x) == dtab[k][0] && int'(e.y) == dtab[k][1]) begin
                    dhit[k] = 1;
                    chk("pt_hsync", hsync, dtab[k][2]);
                    chk("pt_vsync", vsync, dtab[k][3]);
                    chk("pt_video_on", video_on, dtab[k][4]);
`ifdef VGA_TEST_PATTERN_EN
                    chk("pt_rgb", rgb, dtab[k][5]);
`else
                    chk("pt_rgb", rgb, 0);
`endif
                end
        end
        if (rst_n && frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_cnt >= 2 && fs_cnt <= 3) begin
                chk("frame_interval", clk_n - last_fs, 2 * HT * VT);
                intervals++;
            end
            last_fs = clk_n;
        end
    end

    initial begin
        logic h;
        int n, hits;
        model_reset();
        #1 rst_n = 1'b0;
        #1 reset_checks();
        cyc(0);
        cyc(0);
        rst_n = 1'b1;
        h = 1'b0;
        n = 0;
        while (!(mx == 10'd20 && my == 10'd4) && n < 2000) begin
            h = ~h;
            cyc(h);
            n++;
        end
        chk("reach_20_4", n < 2000, 1);
        #2 rst_n = 1'b0;
        q.delete();
        model_reset();
        #1 reset_checks();
        cyc(1);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 10; i++) cyc(1);
        chk("hold_x", x, 1);
        chk("hold_y", y, 0);
        h = 1'b1;
        n = 0;
        while (mpulses < 3 && n < 20000) begin
            h = ~h;
            cyc(h);
            n++;
        end
        chk("steady_frames", n < 20000, 1);
        for (int i = 0; i < 1500; i++) cyc(((i * 5) % 11) > 4);
        for (int i = 0; i < 10; i++) cyc(0);
        for (int i = 0; i < 4; i++) cyc(i[0]);
        @(negedge clk);
        #1;
        chk("frame_intervals_seen", intervals, 2);
        hits = 0;
        for (int k = 0; k < ND; k++) hits += int'(dhit[k]);
        chk("directed_points_seen", hits, ND);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
